// File: rtl/bus_pkg.sv
// bus_pkg: FSM state codes, master count and one-hot master codes shared with the arbiter
package bus_pkg;
  localparam int NM = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [NM-1:0] TIC = 4'b0001;
  localparam logic [NM-1:0] ONE = 4'b0010;
  localparam logic [NM-1:0] TWO = 4'b0100;
  localparam logic [NM-1:0] ARM = 4'b1000;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: flags an exactly-one-hot vector and returns the index of its set bit
module onehot_dec #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_vec,
  output logic                 o_valid,
  output logic [$clog2(N)-1:0] o_idx
);
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < N; k++) if (i_vec[k]) o_idx = k[$clog2(N)-1:0];
  end
  assign o_valid = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);
endmodule

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: runs one granted master's transfer on the shared bus with a ready timeout
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic [NM-1:0]    i_gnt,
  input  logic [NM-1:0]    i_valid,
  input  logic [NM*AW-1:0] i_addr,
  input  logic [NM*DW-1:0] i_wdata,
  input  logic [NM-1:0]    i_we,
  input  logic [DW-1:0]    i_bus_rdata,
  input  logic             i_bus_rdy,
  output logic [AW-1:0]    o_bus_addr,
  output logic [DW-1:0]    o_bus_wdata,
  output logic             o_bus_we,
  output logic             o_bus_sel,
  output logic [DW-1:0]    o_rdata,
  output logic [NM-1:0]    o_ack,
  output logic [NM-1:0]    o_err,
  output logic [NM-1:0]    o_owner,
  output logic             o_busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(NM);
  logic [1:0]    state_q, state_d;
  logic [NM-1:0] owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic          we_q, we_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_ok, start, act;
  logic [IW-1:0] gnt_idx;

  onehot_dec #(.N(NM)) u_dec (.i_vec(i_gnt), .o_valid(gnt_ok), .o_idx(gnt_idx));

  assign start = gnt_ok && ((i_gnt & i_valid) != '0);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ADDR;
        owner_d = i_gnt;
        addr_d  = i_addr[gnt_idx*AW +: AW];
        wdata_d = i_wdata[gnt_idx*DW +: DW];
        we_d    = i_we[gnt_idx];
        err_d   = 1'b0;
      end
      ADDR: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      // ready in the last allowed cycle is checked first, so it beats the timeout
      DATA: if (i_bus_rdy) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : i_bus_rdata;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      owner_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign act         = (state_q == ADDR) || (state_q == DATA);
  assign o_bus_sel   = act;
  assign o_bus_addr  = act ? addr_q : '0;
  assign o_bus_wdata = act ? wdata_q : '0;
  assign o_bus_we    = act && we_q;
  assign o_ack       = (state_q == DONE) ? owner_q : '0;
  assign o_err       = (state_q == DONE && err_q) ? owner_q : '0;
  assign o_owner     = owner_q;
  assign o_busy      = state_q != IDLE;
  assign o_rdata     = rdata_q;
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb_bus_xfer_ctrl: table-driven transfers plus hand sequences for reset and grant changes
module tb_bus_xfer_ctrl;
  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic [3:0]  i_gnt, i_valid, i_we;
  logic [63:0] i_addr;
  logic [31:0] i_wdata;
  logic [7:0]  i_bus_rdata;
  logic        i_bus_rdy;
  logic [15:0] o_bus_addr;
  logic [7:0]  o_bus_wdata, o_rdata;
  logic        o_bus_we, o_bus_sel, o_busy;
  logic [3:0]  o_ack, o_err, o_owner;

  bus_xfer_ctrl dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_gnt(i_gnt), .i_valid(i_valid),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_we(i_we),
    .i_bus_rdata(i_bus_rdata), .i_bus_rdy(i_bus_rdy),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_we(o_bus_we),
    .o_bus_sel(o_bus_sel), .o_rdata(o_rdata), .o_ack(o_ack), .o_err(o_err),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  gnt;
    logic [3:0]  valid;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          rdy_at;
    logic        start;
    int          dcyc;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[7];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_masters(input logic [3:0] gnt, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic we);
    for (int k = 0; k < 4; k++) begin
      i_addr[k*16 +: 16] = gnt[k] ? addr : 16'hF000 + 16'(k);
      i_wdata[k*8 +: 8]  = gnt[k] ? wdata : 8'hE0 + 8'(k);
      i_we[k]            = gnt[k] ? we : ~we;
    end
  endtask

  task automatic run(input vec_t v);
    int n;
    i_gnt = v.gnt;
    i_valid = v.valid;
    i_bus_rdy = 1'b0;
    i_bus_rdata = v.rdata;
    set_masters(v.gnt, v.addr, v.wdata, v.we);
    @(negedge i_clk);
    i_gnt = '0;
    i_valid = '0;
    chk("start_busy", 32'(o_busy), 32'(v.start));
    if (!v.start) begin
      chk("idle_owner", 32'(o_owner), 0);
      chk("idle_sel", 32'(o_bus_sel), 0);
      return;
    end
    chk("addr_owner", 32'(o_owner), 32'(v.gnt));
    chk("addr_sel", 32'(o_bus_sel), 1);
    chk("addr_bus_addr", 32'(o_bus_addr), 32'(v.addr));
    chk("addr_bus_wdata", 32'(o_bus_wdata), 32'(v.wdata));
    chk("addr_bus_we", 32'(o_bus_we), 32'(v.we));
    @(negedge i_clk);
    n = 0;
    while (o_busy && o_ack == '0 && n < 40) begin
      chk("data_sel", 32'(o_bus_sel), 1);
      chk("data_bus_we", 32'(o_bus_we), 32'(v.we));
      chk("data_bus_wdata", 32'(o_bus_wdata), 32'(v.wdata));
      i_bus_rdy = (n == v.rdy_at);
      n++;
      @(negedge i_clk);
    end
    i_bus_rdy = 1'b0;
    chk("data_cycles", 32'(n), 32'(v.dcyc));
    chk("done_ack", 32'(o_ack), 32'(v.ack));
    chk("done_err", 32'(o_err), 32'(v.err));
    chk("done_rdata", 32'(o_rdata), 32'(v.exp_rdata));
    chk("done_sel", 32'(o_bus_sel), 0);
    @(negedge i_clk);
    chk("post_ack", 32'(o_ack), 0);
    chk("post_busy", 32'(o_busy), 0);
    chk("post_owner", 32'(o_owner), 0);
  endtask

  initial begin
    vecs[0] = '{4'b0010, 4'b1111, 1'b0, 16'h1234, 8'h00, 8'hA5, 0,  1'b1, 1,  4'b0010, 4'b0000, 8'hA5};
    vecs[1] = '{4'b1000, 4'b1000, 1'b1, 16'h4000, 8'h3C, 8'h77, 3,  1'b1, 4,  4'b1000, 4'b0000, 8'hA5};
    vecs[2] = '{4'b0001, 4'b0001, 1'b0, 16'h0010, 8'h00, 8'h99, -1, 1'b1, 15, 4'b0001, 4'b0001, 8'hA5};
    vecs[3] = '{4'b0100, 4'b0100, 1'b0, 16'h2222, 8'h00, 8'h5A, 14, 1'b1, 15, 4'b0100, 4'b0000, 8'h5A};
    vecs[4] = '{4'b0110, 4'b1111, 1'b0, 16'h6666, 8'h00, 8'h00, 0,  1'b0, 0,  4'b0000, 4'b0000, 8'h5A};
    vecs[5] = '{4'b0100, 4'b1011, 1'b0, 16'h5555, 8'h00, 8'h00, 0,  1'b0, 0,  4'b0000, 4'b0000, 8'h5A};
    vecs[6] = '{4'b0000, 4'b1111, 1'b0, 16'h7777, 8'h00, 8'h00, 0,  1'b0, 0,  4'b0000, 4'b0000, 8'h5A};

    i_nrst = 1'b0;
    i_gnt = 4'b0010;
    i_valid = 4'b1111;
    i_bus_rdy = 1'b0;
    i_bus_rdata = 8'h00;
    set_masters(4'b0010, 16'hBEEF, 8'h11, 1'b1);
    repeat (3) @(negedge i_clk);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_sel", 32'(o_bus_sel), 0);
    chk("rst_owner", 32'(o_owner), 0);
    chk("rst_ack", 32'(o_ack), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_rdata", 32'(o_rdata), 0);
    chk("rst_addr", 32'(o_bus_addr), 0);
    chk("rst_we_wdata", 32'({o_bus_we, o_bus_wdata}), 0);
    i_nrst = 1'b1;
    @(negedge i_clk);
    chk("rel_busy", 32'(o_busy), 1);
    chk("rel_owner", 32'(o_owner), 32'(4'b0010));
    chk("rel_addr", 32'(o_bus_addr), 32'(16'hBEEF));
    i_gnt = '0;
    i_valid = '0;
    i_bus_rdy = 1'b1;
    for (int k = 0; k < 6 && o_ack == '0; k++) @(negedge i_clk);
    i_bus_rdy = 1'b0;
    chk("rel_ack", 32'(o_ack), 32'(4'b0010));
    chk("rel_rdata", 32'(o_rdata), 0);
    @(negedge i_clk);
    chk("rel_idle", 32'(o_busy), 0);

    for (int i = 0; i < 7; i++) run(vecs[i]);

    i_gnt = 4'b0100;
    i_valid = 4'b0100;
    set_masters(4'b0100, 16'h3333, 8'h42, 1'b1);
    @(negedge i_clk);
    chk("chg_addr_owner", 32'(o_owner), 32'(4'b0100));
    @(negedge i_clk);
    i_gnt = 4'b0001;
    i_valid = 4'b0001;
    repeat (2) begin
      @(negedge i_clk);
      chk("chg_owner", 32'(o_owner), 32'(4'b0100));
      chk("chg_bus_addr", 32'(o_bus_addr), 32'(16'h3333));
    end
    i_gnt = '0;
    i_valid = '0;
    i_bus_rdy = 1'b1;
    @(negedge i_clk);
    i_bus_rdy = 1'b0;
    chk("chg_ack", 32'(o_ack), 32'(4'b0100));
    chk("chg_rdata", 32'(o_rdata), 32'(8'h5A));
    @(negedge i_clk);
    chk("chg_idle", 32'(o_busy), 0);

    i_gnt = 4'b0001;
    i_valid = 4'b0001;
    set_masters(4'b0001, 16'h0ABC, 8'h00, 1'b0);
    @(negedge i_clk);
    i_gnt = '0;
    i_valid = '0;
    @(negedge i_clk);
    chk("mid_sel_before", 32'(o_bus_sel), 1);
    #2 i_nrst = 1'b0;
    i_bus_rdy = 1'b1;
    #1;
    chk("mid_sel", 32'(o_bus_sel), 0);
    chk("mid_busy", 32'(o_busy), 0);
    chk("mid_owner", 32'(o_owner), 0);
    repeat (2) begin
      @(negedge i_clk);
      chk("mid_no_ack", 32'(o_ack), 0);
    end
    i_bus_rdy = 1'b0;
    i_nrst = 1'b1;
    @(negedge i_clk);
    chk("mid_rel_idle", 32'(o_busy), 0);
    chk("mid_rel_rdata", 32'(o_rdata), 0);
    run(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
